// File: rtl/acc_requant.sv
// acc_requant: streaming requantiser for signed MAC accumulators.
// Stage 1 applies an arithmetic right shift with round-half-up in AW+1 bits.
// Stage 2 saturates to signed W bits and drives the output register.
// Both stages use valid/ready handshakes and sustain one element per cycle.
// Optional feature: define ACC_REQUANT_SAT_CNT_EN to add the sat_clr and sat_count ports
// and a sticky 16-bit saturation-event counter. The datapath is the same in both builds.
module acc_requant #(
  parameter int AW = 32,
  parameter int W  = 8,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_acc,
  input  logic [SW-1:0] in_shift,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last
`ifdef ACC_REQUANT_SAT_CNT_EN
  ,
  input  logic          sat_clr,
  output logic [15:0]   sat_count
`endif
);

  logic                 s1_valid;
  logic                 s1_last;
  logic signed [AW:0]   s1_r;

  logic                 adv1;
  logic                 adv2;
  logic                 ld1;
  logic                 ld2;

  logic signed [AW:0]   acc_ext;
  logic signed [AW:0]   rnd;
  logic signed [AW:0]   sum;
  logic signed [AW:0]   r_next;

  logic                 hi_ovf;
  logic                 lo_ovf;
  logic [W-1:0]         q_next;

  // Handshake: each stage advances when it is empty or its consumer takes the data.
  always_comb begin
    adv2     = !out_valid || out_ready;
    adv1     = !s1_valid || adv2;
    in_ready = adv1;
    ld1      = in_valid && adv1;
    ld2      = s1_valid && adv2;
  end

  // Round-half-up shift. The extra guard bit keeps the rounding add from overflowing.
  always_comb begin
    acc_ext = {in_acc[AW-1], in_acc};
    rnd     = '0;
    if (in_shift != '0) begin
      rnd = (AW+1)'(1) << (in_shift - SW'(1));
    end
    sum    = acc_ext + rnd;
    r_next = sum >>> in_shift;
  end

  // Saturate to signed W bits. In range means bits AW..W-1 all equal the sign.
  always_comb begin
    hi_ovf = !s1_r[AW] && (|s1_r[AW-1:W-1]);
    lo_ovf = s1_r[AW] && !(&s1_r[AW-1:W-1]);
    q_next = s1_r[W-1:0];
    if (hi_ovf) begin
      q_next = {1'b0, {(W-1){1'b1}}};
    end else if (lo_ovf) begin
      q_next = {1'b1, {(W-1){1'b0}}};
    end
  end

  // Stage 1 register: rounded and shifted value plus the last flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_last  <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
      end
      if (ld1) begin
        s1_r    <= r_next;
        s1_last <= in_last;
      end
    end
  end

  // Stage 2 register: saturated output. Data holds while the stage is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (adv2) begin
        out_valid <= s1_valid;
      end
      if (ld2) begin
        out_data <= q_next;
        out_last <= s1_last;
      end
    end
  end

`ifdef ACC_REQUANT_SAT_CNT_EN
  logic sat_event;

  // Saturation is active when stage 2 clips the value.
  always_comb begin
    sat_event = hi_ovf || lo_ovf;
  end

  // Sticky counter of clipped stage-2 loads. Clear wins over an increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (ld2 && sat_event && (sat_count != '1)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule
